// File: rtl/bcd_scan_pkg.sv
// Shared types, constants and helpers for the BCD scan counter.
package bcd_scan_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic bcd_digit_t clamp_bcd(input bcd_digit_t nib);
    bcd_digit_t res;
    if (nib > BCD_MAX) begin
      res = BCD_MAX;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: clear > load > carry/borrow step, with a combinational
// carry/borrow out to the next decade.
module bcd_decade
  import bcd_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_load,
  input  bcd_digit_t i_load_val,
  input  logic       i_up,
  input  logic       i_cin,
  output bcd_digit_t o_digit,
  output logic       o_cout
);

  bcd_digit_t r_digit;
  bcd_digit_t w_next;
  logic       w_at_limit;

  always_comb begin
    w_at_limit = i_up ? (r_digit == BCD_MAX) : (r_digit == BCD_ZERO);
    w_next     = r_digit;
    if (i_clear) begin
      w_next = BCD_ZERO;
    end else if (i_load) begin
      w_next = clamp_bcd(i_load_val);
    end else if (i_cin) begin
      if (w_at_limit) begin
        w_next = i_up ? BCD_ZERO : BCD_MAX;
      end else begin
        w_next = i_up ? (r_digit + 4'd1) : (r_digit - 4'd1);
      end
    end else begin
      w_next = r_digit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= BCD_ZERO;
    end else begin
      r_digit <= w_next;
    end
  end

  assign o_digit = r_digit;
  // i_cin is already gated off by clear/load, so an ignored step never ripples.
  assign o_cout  = i_cin & w_at_limit;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with multiplexed display scanning.
// Optional leading-zero blanking when BCD_SCAN_BLANK_EN is defined.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    step,
  input  logic                    up,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    wrap,
  output logic                    load_err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  bcd_digit_t            w_digits [NUM_DIGITS];
  logic [NUM_DIGITS:0]   w_carry;
  logic [NUM_DIGITS-1:0] w_clamped;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [NUM_DIGITS-1:0] w_sel;

  logic [DIV_W-1:0]      r_div;
  logic [IDX_W-1:0]      r_idx;
  bcd_digit_t            r_digit;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_wrap;
  logic                  r_load_err;

  assign w_carry[0] = step & ~clear & ~load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decade
    bcd_decade u_decade (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (clear),
      .i_load     (load),
      .i_load_val (load_val[4*g +: 4]),
      .i_up       (up),
      .i_cin      (w_carry[g]),
      .o_digit    (w_digits[g]),
      .o_cout     (w_carry[g+1])
    );
    assign w_clamped[g] = (load_val[4*g +: 4] > BCD_MAX);
  end

`ifdef BCD_SCAN_BLANK_EN
  // A digit is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic v_zero;
    v_zero  = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      v_zero     = v_zero & (w_digits[i] == BCD_ZERO);
      w_blank[i] = v_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_sel = AN_ONE << r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : (r_idx + IDX_W'(1));
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // digit and anode come from the same registered index, so they switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit    <= BCD_ZERO;
      r_an       <= ~AN_ONE;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_digit    <= w_digits[r_idx];
      r_an       <= ~w_sel | (w_blank & w_sel);
      r_wrap     <= w_carry[NUM_DIGITS];
      r_load_err <= load & ~clear & (|w_clamped);
    end
  end

  assign digit_bcd = r_digit;
  assign an        = r_an;
  assign wrap      = r_wrap;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter using an integer-valued reference model.
module tb_bcd_scan_counter;

  localparam int N  = 4;
  localparam int SD = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clear = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] load_val = '0;
  logic           step = 1'b0;
  logic           up = 1'b0;
  logic [3:0]     digit_bcd;
  logic [N-1:0]   an;
  logic           wrap;
  logic           load_err;

  int total = 0;
  int bad   = 0;
  int p10 [0:N];
  int m_count;
  int m_cyc;
  logic [3:0]   e_digit;
  logic [N-1:0] e_an;
  logic         e_wrap;
  logic         e_err;

  bcd_scan_counter #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .step      (step),
    .up        (up),
    .digit_bcd (digit_bcd),
    .an        (an),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict the outputs after the edge, advance the model.
  task automatic tick(input logic c, input logic l, input logic [4*N-1:0] lv,
                      input logic s, input logic u);
    int idx;
    int nv;
    int nib;
    clear = c; load = l; load_val = lv; step = s; up = u;
    idx     = (m_cyc / SD) % N;
    e_digit = 4'((m_count / p10[idx]) % 10);
    e_an    = ~(N'(1) << idx);
`ifdef BCD_SCAN_BLANK_EN
    if (idx > 0 && m_count < p10[idx]) e_an = e_an | (N'(1) << idx);
`endif
    e_wrap = 1'b0;
    e_err  = 1'b0;
    nv     = m_count;
    if (c) begin
      nv = 0;
    end else if (l) begin
      nv = 0;
      for (int i = 0; i < N; i++) begin
        nib = int'(lv[4*i +: 4]);
        if (nib > 9) begin
          nib   = 9;
          e_err = 1'b1;
        end
        nv += nib * p10[i];
      end
    end else if (s) begin
      nv = u ? m_count + 1 : m_count - 1;
      if (nv >= p10[N]) begin nv = 0; e_wrap = 1'b1; end
      if (nv < 0) begin nv = p10[N] - 1; e_wrap = 1'b1; end
    end
    @(posedge clk);
    m_count = nv;
    m_cyc++;
    #1;
    clear = 1'b0; load = 1'b0; step = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_count = 0;
    m_cyc   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({digit_bcd, an, wrap, load_err} !== {4'd0, 4'b1110, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got digit=%0d an=%b wrap=%b err=%b, want 0 1110 0 0", digit_bcd, an, wrap, load_err);
    end
    release_reset();
    for (int k = 0; k < N * SD + 2; k++) begin
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL reset_scan k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  task automatic test_increment();
    for (int k = 0; k < 3 + N * SD; k++) begin
      if (k == 0) tick(1'b0, 1'b1, 16'h0998, 1'b0, 1'b0);
      else if (k < 3) tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
      else tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL increment k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      case (k)
        0:       tick(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
        1:       tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
        3:       tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        5, 6, 7: tick(1'b0, 1'b0, '0, 1'b1, k[0]);
        default: tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      endcase
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL wrap k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  task automatic test_scan(input logic [4*N-1:0] val, input string name);
    for (int k = 0; k < 1 + 2 * N * SD; k++) begin
      if (k == 0) tick(1'b0, 1'b1, val, 1'b0, 1'b0);
      else tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL %s k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", name, k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  task automatic test_priority();
    for (int k = 0; k < 4 + N * SD; k++) begin
      if (k == 0) tick(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
      else if (k == 1) tick(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
      else if (k == 2) tick(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
      else if (k == 3) tick(1'b0, 1'b1, 16'h0A0F, 1'b0, 1'b0);
      else tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL priority k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [4*N-1:0] lv;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        2:       lv = 16'h9998;
        default: lv = 16'($urandom);
      endcase
      tick(r < 3, r < 10, lv, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL random k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (m_cyc % (N * SD) != 2 * SD && guard < 100) begin
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      guard++;
    end
    tick(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
    total++;
    if ({an, wrap} !== {4'b1011, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset: got an=%b wrap=%b want 1011 1", an, wrap);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({digit_bcd, an, wrap, load_err} !== {4'd0, 4'b1110, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got digit=%0d an=%b wrap=%b err=%b, want 0 1110 0 0", digit_bcd, an, wrap, load_err);
    end
    release_reset();
    for (int k = 0; k < N * SD + 2; k++) begin
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if ({digit_bcd, an, wrap, load_err} !== {e_digit, e_an, e_wrap, e_err}) begin
        bad++;
        $display("FAIL mid_reset_scan k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k, digit_bcd, an, wrap, load_err, e_digit, e_an, e_wrap, e_err);
      end
    end
  endtask

  initial begin
    p10[0] = 1;
    for (int i = 1; i <= N; i++) p10[i] = p10[i-1] * 10;
    m_count = 0;
    m_cyc   = 0;
    test_reset();
    test_increment();
    test_wrap();
    test_scan(16'h4321, "scan");
    test_scan(16'h0042, "leading_zero");
    test_priority();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit BCD up/down counter with time-multiplexed display scanning.
- Sits directly upstream of the 7-segment decoder: drives its 4-bit digit input (x3..x0) and the shared display's active-low anode enables.
- Each cycle of the output presents exactly one digit, always a value in 0-9, to the decoder.

Parameters:
- NUM_DIGITS, 4: number of BCD decades and anodes; legal range 1-8.
- SCAN_DIV, 16: clock cycles each digit stays selected; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of the count to zero.
- load  input  1  synchronous load of load_val.
- load_val  input  4*NUM_DIGITS  packed BCD value; digit 0 is in bits [3:0].
- step  input  1  one-cycle count-step request.
- up  input  1  count direction: 1 = increment, 0 = decrement.
- digit_bcd  output  4  BCD digit to the decoder; bit 3 drives x3, bit 0 drives x0.
- an  output  NUM_DIGITS  active-low anode one-hot; bit i selects digit i.
- wrap  output  1  one-cycle pulse on count roll-over or roll-under.
- load_err  output  1  one-cycle pulse when a loaded nibble exceeded 9.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately including mid-scan):
  - count=0, scan divider=0, scan index=0.
  - an={NUM_DIGITS-1 ones,0}, i.e. digit 0 active.
  - digit_bcd=0, wrap=0, load_err=0.
- Count update priority per cycle is clear > load > step.
  - The lower-priority request in the same cycle is ignored entirely; no wrap is produced by an ignored step.
- load: each nibble >9 is stored as 9; load_err pulses in the next cycle if any nibble was clamped.
- step with up=1: ripple-carry BCD increment (9 -> 0 with carry into the next decade).
  - All-9s -> all-0s asserts wrap for exactly one cycle.
- step with up=0: BCD decrement with borrow (0 -> 9).
  - All-0s -> all-9s asserts wrap for exactly one cycle.
- step held high counts once per cycle; back-to-back wraps give back-to-back wrap pulses.
- Scan:
  - The divider counts 0..SCAN_DIV-1.
  - On the terminal count it returns to 0 and the scan index advances modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
  - SCAN_DIV=1 advances the index every cycle.
- Outputs are registered:
  - digit_bcd = count nibble at the current scan index.
  - an = ~(1 << index).
  - Both reflect a count change or index change one cycle after the edge that produced it.
  - digit_bcd and an always change on the same edge, so there is no cross-digit glitch.
- Clear, load and step never disturb the scan divider or the scan index.
- digit_bcd never exceeds 9. The downstream decoder is undefined for 10-15, so this is a hard invariant.

Optional Feature:
- Macro: BCD_SCAN_BLANK_EN.
- When defined: leading zero digits are blanked. Any digit i > 0 whose value and all higher digits are 0 gets its an bit forced to 1 (off) during its scan slot. digit_bcd still outputs 0 for that slot. Digit 0 is never blanked, so a count of 0 shows a single "0".
- When undefined: all digits are always displayed, and the an one-hot is unconditional.

Decomposition:
- Shared package bcd_scan_pkg:
  - BCD_MAX=4'd9.
  - BCD_ZERO=4'd0.
  - typedef bcd_digit_t (4 bits).
  - Function clamp_bcd (nibble >9 -> 9).
- One natural sub-module, bcd_decade:
  - Single-digit counter with carry/borrow in and out, plus synchronous clear and load.
  - Instantiated NUM_DIGITS times in a generate loop.
- Scan divider, index, and output registers live in the top level.

Test Plan:
- Mid-scan reset (NUM_DIGITS=4, SCAN_DIV=4): assert rst asynchronously at index 2 -> without waiting for a clock edge, an=4'b1110, digit_bcd=0, wrap=0, count=0000.
- Increment across decades: load 16'h0998, then step up=1 for two cycles -> count 0999 then 1000, wrap stays 0; with index 3 selected, digit_bcd shows 1.
- Roll-over and roll-under:
  - Load 16'h9999, one up step -> count 0000, wrap high for exactly one cycle.
  - Then one step with up=0 -> count 9999, wrap pulses again.
- Scan sequence (SCAN_DIV=4, count 16'h4321): an cycles 1110, 1101, 1011, 0111, each held 4 clocks, with digit_bcd 1, 2, 3, 4 respectively; after 0111 it returns to 1110.
- Priority and clamping:
  - clear, load=16'h5555 and step all in the same cycle -> count 0000, no wrap.
  - Load 16'h0A0F -> count 0909, load_err pulses once.
- BCD_SCAN_BLANK_EN defined, count 0042 -> an bits 3 and 2 stay 1 during their slots; digits 1 and 0 are displayed as 4 and 2.
